prescaled_timer_counter: RTL and testbench
==========================================

Name: prescaled_timer_counter

Overview:
Parametrised successor to the plain free-running counter. Adds a prescaler, a programmable terminal count with automatic wrap, a one-shot mode, start/stop control, and a one-cycle match pulse. It is used as the CPU-side timer peripheral and as a general tick generator. Configured with period at its maximum value, prescale=0 and one_shot=0, it behaves as a free-running counter after start.

Parameters:
WIDTH, 32, width of count and period.
PRESCALE_WIDTH, 16, width of the prescale divider. The divide ratio is prescale+1.

Ports:
clk  in  1  clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  single-cycle pulse: latch the configuration and (re)start counting from 0.
stop  in  1  single-cycle pulse: halt counting and hold count.
one_shot  in  1  mode, sampled at start. 1 = stop at terminal count; 0 = auto-wrap.
prescale  in  PRESCALE_WIDTH  step every prescale+1 clocks; sampled at start.
period  in  WIDTH  terminal count value; sampled at start.
count  out  WIDTH  current count; registered.
running  out  1  high while in state RUN.
match  out  1  one-cycle pulse when the terminal count is passed.
done  out  1  sticky flag: a one-shot run has completed. Cleared by start or reset.

Behaviour:
- Reset:
  - count=0, running=0, match=0, done=0.
  - Internal prescaler counter pre_cnt=0; shadow registers period_s, prescale_s, one_shot_s all 0; state IDLE.
  - Reset has priority over everything else.
- States: IDLE and RUN. running is high exactly when the state is RUN.
- Priority among controls: reset > stop > start > counting.
- Start (any state, stop low):
  - Latch period_s, prescale_s and one_shot_s from the inputs.
  - count<=0, pre_cnt<=0, done<=0, match<=0, state<=RUN.
  - A start while already in RUN is a restart with the same effect.
- Stop: in RUN, state<=IDLE. count holds its value, pre_cnt<=0, match<=0. In IDLE, stop has no effect.
- Step generation in RUN:
  - Each cycle: if pre_cnt==prescale_s, then pre_cnt<=0 and a step occurs; otherwise pre_cnt<=pre_cnt+1.
  - With prescale_s=0, a step occurs every cycle.
- On a step:
  - If count!=period_s: count<=count+1.
  - If count==period_s: match<=1 for the next cycle only, then:
    - one_shot_s=0: count<=0 and counting continues.
    - one_shot_s=1: count holds period_s, done<=1, state<=IDLE.
- match is low in every cycle in which it is not generated by the step rule above.
- Timing:
  - The first increment happens prescale_s+1 cycles after the start edge.
  - Match period is (period_s+1)*(prescale_s+1) cycles.
  - match rises on the same edge at which count returns to 0 (auto-wrap) or at which running falls (one-shot).
- Boundaries:
  - period=0: count stays 0 and match pulses every prescale_s+1 cycles. In one-shot mode, done sets after the first step.
  - period=2^WIDTH-1: the wrap to 0 happens through the match path; count never overflows silently.
  - count never exceeds period_s.
  - Input changes to period, prescale or one_shot while in RUN have no effect until the next start.
  - A start in the same cycle as a terminal step: the restart wins and no match pulse is generated.
  - Start and stop in the same cycle: stop wins. From IDLE this is a no-op.
  - Reset mid-run: all outputs return to their reset values on the next edge.
- Arithmetic: all counters are unsigned and wrap modulo their width. pre_cnt is PRESCALE_WIDTH bits.

Test Plan:
1. Reset, then start with period=3, prescale=0, one_shot=0.
   -> count sequence 0,1,2,3,0,1,…
   -> match high for 1 cycle each time count becomes 0, i.e. every 4 cycles.
   -> running=1 throughout.
2. Start with period=1, prescale=2.
   -> count changes every 3 cycles (0,0,0,1,1,1,0…).
   -> match pulses every 6 cycles.
3. Start with one_shot=1, period=2, prescale=0.
   -> count 0,1,2, then holds 2.
   -> exactly one match pulse; running falls and done rises on the same edge.
   -> a second start clears done and restarts from 0.
4. Stop while count=5 (period=10).
   -> count holds 5, running=0, no match.
   -> start again: count=0 and counting resumes.
5. Change period to 7 during a run with period=3.
   -> wrap remains at 3 until the next start, then wraps at 7.
   -> start and stop asserted together: running=0.
6. WIDTH=4, period=15.
   -> wrap 15->0 with a match pulse.
   -> assert reset at count=9: next cycle count=0, running=0, match=0, done=0.

Source files
------------

// File: rtl/prescaled_timer_counter.sv
// Prescaled timer/counter with programmable terminal count, auto-wrap or one-shot mode,
// start/stop control, a one-cycle match pulse and a sticky done flag.
module prescaled_timer_counter #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      one_shot,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [WIDTH-1:0]          period,
    output logic [WIDTH-1:0]          count,
    output logic                      running,
    output logic                      match,
    output logic                      done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [WIDTH-1:0]          count_next;
    logic [PRESCALE_WIDTH-1:0] pre_cnt;
    logic [PRESCALE_WIDTH-1:0] pre_cnt_next;
    logic [WIDTH-1:0]          period_s;
    logic [WIDTH-1:0]          period_s_next;
    logic [PRESCALE_WIDTH-1:0] prescale_s;
    logic [PRESCALE_WIDTH-1:0] prescale_s_next;
    logic                      one_shot_s;
    logic                      one_shot_s_next;
    logic                      match_next;
    logic                      done_next;
    logic                      step;
    logic                      terminal;

    // State, counters, shadow configuration and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            count      <= '0;
            pre_cnt    <= '0;
            period_s   <= '0;
            prescale_s <= '0;
            one_shot_s <= 1'b0;
            match      <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            pre_cnt    <= pre_cnt_next;
            period_s   <= period_s_next;
            prescale_s <= prescale_s_next;
            one_shot_s <= one_shot_s_next;
            match      <= match_next;
            done       <= done_next;
        end
    end

    assign running  = (state == ST_RUN);
    assign step     = (pre_cnt == prescale_s);
    assign terminal = (count == period_s);

    // Next-state logic; priority is stop > start > counting
    always_comb begin
        state_next      = state;
        count_next      = count;
        pre_cnt_next    = pre_cnt;
        period_s_next   = period_s;
        prescale_s_next = prescale_s;
        one_shot_s_next = one_shot_s;
        match_next      = 1'b0;
        done_next       = done;

        if (stop) begin
            // Stop from IDLE (including a simultaneous start) changes nothing
            if (state == ST_RUN) begin
                state_next   = ST_IDLE;
                pre_cnt_next = '0;
            end
        end else if (start) begin
            period_s_next   = period;
            prescale_s_next = prescale;
            one_shot_s_next = one_shot;
            count_next      = '0;
            pre_cnt_next    = '0;
            done_next       = 1'b0;
            state_next      = ST_RUN;
        end else if (state == ST_RUN) begin
            if (step) begin
                pre_cnt_next = '0;
                if (!terminal) begin
                    count_next = count + WIDTH'(1);
                end else begin
                    // Terminal step: wrap through zero or finish the one-shot run
                    match_next = 1'b1;
                    if (one_shot_s) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        count_next = '0;
                    end
                end
            end else begin
                pre_cnt_next = pre_cnt + PRESCALE_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_prescaled_timer_counter.sv
// Scoreboard bench: a driver feeds directed and random control sequences and pushes the
// expected outputs from an elapsed-time model; a monitor pops and compares after each edge.
module tb_prescaled_timer_counter;

    localparam int unsigned W  = 4;
    localparam int unsigned PW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          one_shot = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic [W-1:0]  period = '0;
    logic [W-1:0]  count;
    logic          running;
    logic          match;
    logic          done;

    always #5 clk = ~clk;

    prescaled_timer_counter #(
        .WIDTH          (W),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .one_shot (one_shot),
        .prescale (prescale),
        .period   (period),
        .count    (count),
        .running  (running),
        .match    (match),
        .done     (done)
    );

    typedef struct packed {
        logic [W-1:0] count;
        logic         running;
        logic         match;
        logic         done;
    } exp_t;

    exp_t exp_q[$];
    exp_t got;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Reference model: outputs follow from cycles elapsed since the last start
    bit     m_active = 1'b0;
    bit     m_done = 1'b0;
    bit     m_os = 1'b0;
    longint m_e = 0;
    int     m_per = 0;
    int     m_ps = 0;
    int     m_hold = 0;

    function automatic int model_count();
        if (m_active)
            return int'((m_e / longint'(m_ps + 1)) % longint'(m_per + 1));
        return m_hold;
    endfunction

    task automatic drive(input bit rst, input bit st, input bit sp, input bit os,
                         input int ps, input int per);
        exp_t   e;
        bit     mt;
        longint steps;
        @(negedge clk);
        reset    = rst;
        start    = st;
        stop     = sp;
        one_shot = os;
        prescale = PW'(ps);
        period   = W'(per);
        mt = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_hold   = 0;
        end else if (sp) begin
            if (m_active) begin
                m_hold   = model_count();
                m_active = 1'b0;
            end
        end else if (st) begin
            m_per    = per;
            m_ps     = ps;
            m_os     = os;
            m_e      = 0;
            m_active = 1'b1;
            m_done   = 1'b0;
        end else if (m_active) begin
            m_e++;
            steps = m_e / longint'(m_ps + 1);
            if ((m_e % longint'(m_ps + 1)) == 0 && (steps % longint'(m_per + 1)) == 0) begin
                mt = 1'b1;
                if (m_os) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                    m_hold   = m_per;
                end
            end
        end
        e.count   = W'(model_count());
        e.running = m_active;
        e.match   = mt;
        e.done    = m_done;
        exp_q.push_back(e);
    endtask

    // Idle cycles with random configuration inputs, which must be ignored while running
    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cyc, act, req);
        end
    endtask

    // Monitor: compare DUT outputs with the oldest expectation after each rising edge
    always @(posedge clk) begin
        #2;
        cyc++;
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            chk("count", 32'(count), 32'(got.count));
            chk("running", 32'(running), 32'(got.running));
            chk("match", 32'(match), 32'(got.match));
            chk("done", 32'(done), 32'(got.done));
        end
    end

    initial begin
        int r;
        int per;
        bit st;
        bit sp;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

        // Auto-wrap at period 3
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 3);
        idle(12);
        // Prescale by 3, period 1
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2, 1);
        idle(14);
        // One-shot then restart
        drive(1'b0, 1'b1, 1'b0, 1'b1, 0, 2);
        idle(8);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 0, 2);
        idle(3);
        // Stop at count 5, then restart
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 10);
        idle(5);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 10);
        idle(4);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 10);
        idle(4);
        // Period changes mid-run are ignored until the next start
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 3);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 7);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 7);
        idle(12);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 7);
        idle(3);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 7);
        idle(2);
        // Full-range period wraps 15 -> 0, then reset mid-run at count 9
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 15);
        idle(20);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 15);
        idle(9);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 15);
        idle(2);
        // Start on a terminal step: restart wins, no match
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 1);
        idle(1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 1);
        idle(2);

        // Random control traffic
        for (int i = 0; i < 2500; i++) begin
            r  = int'($urandom_range(0, 99));
            st = (r >= 1 && r <= 6) || r == 10;
            sp = (r >= 7 && r <= 10);
            if ($urandom_range(0, 1) == 0) per = int'($urandom_range(0, 15));
            else begin
                case ($urandom_range(0, 2))
                    0:       per = 0;
                    1:       per = 1;
                    default: per = 15;
                endcase
            end
            drive(r == 0, st, sp, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), per);
        end

        @(negedge clk);
        @(negedge clk);
        chk("drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
